control_sequencer: RTL and testbench
====================================

// Module: control_sequencer
// PURPOSE
//  Hardwired control unit that drives the datapath register-transfer strobes.
//  Steps an R-format ALU instruction through fetch (T0-T2) and execute (T3-T5).
//  Reads ir back from the datapath and sequences the one-hot in/out enables.
//  Sits beside the datapath; the two share only strobes, ir and mem_ready.
// PARAMETERS
//  OPW          5    opcode width, ir[31:27]
//  MEM_TIMEOUT  15   max cycles waiting for mem_ready before mem_err (>=1)
// PORTS
//  clock      in   1    single clock, all state on rising edge
//  clear      in   1    synchronous, active-high reset
//  run        in   1    level; high = fetch/execute continuously
//  mem_ready  in   1    memory read data valid on mdr_immediate path
//  ir         in   32   instruction register contents from datapath
//  pco,pci    out  1    PC out / PC in
//  inc_pc     out  1    ALU computes PC+1
//  mari       out  1    MAR in
//  read       out  1    memory read request
//  mdri,mdro  out  1    MDR in / MDR out
//  iri        out  1    IR in
//  ryi        out  1    Y in
//  zi,zlo     out  1    Z in / Z-low out
//  gra,grb,grc out 1    select ir Ra[26:23] / Rb[22:19] / Rc[18:15]
//  rin,rout   out  1    selected general register in / out
//  alu_op     out  OPW  operation to ALU, valid while zi=1 in T4
//  done       out  1    one-cycle pulse, instruction retired
//  illegal    out  1    one-cycle pulse, unsupported opcode
//  mem_err    out  1    one-cycle pulse, mem_ready timeout
// BEHAVIOUR
//  - All outputs registered (Moore); clear -> state IDLE, every output 0, timer 0.
//  - clear has priority over every other input in the same cycle.
//  - States/strobes (each asserted for exactly the cycles spent in the state):
//    IDLE: none; run=1 -> T0.
//    T0: pco, mari, inc_pc, zi -> T1.
//    T1: zlo, pci -> TW.
//    TW: read, mdri held; mem_ready=1 -> T2 (same-cycle ready = 1-cycle TW);
//        timer reaches MEM_TIMEOUT with no ready -> mem_err pulse, IDLE.
//    T2: mdro, iri -> T3.
//    T3: decode ir[31:27]; legal -> grb, rout, ryi; illegal -> illegal pulse, IDLE.
//    T4: grc, rout, zi, alu_op=ir[31:27] -> T5.
//    T5: zlo, gra, rin, done -> T0 if run=1 else IDLE.
//  - Legal opcodes: ADD 00011, SUB 00100, AND 00101, OR 00110, SHR 00111,
//    SHL 01001, ROR 01000, ROL 01010; alu_op=0 outside T4.
//  - run deasserted mid-instruction: current instruction completes, then IDLE.
//  - Timer: 4-bit min, counts in TW only, cleared on TW entry; no wrap.
//  - Latency: best case 7 cycles T0..T5 per instruction; +1 per TW stall.
//  - Never two *o strobes together (pco, mdro, zlo, rout): bus exclusivity.
// STRUCTURE
//  - control_defs.vh: opcode localparams, state encodings, OPW default.
//  - Single module; optional sub-module op_decode (opcode -> legal flag).
// TESTING
//  - clear 2 cycles -> all outputs 0, state IDLE; clear during T4 -> IDLE next edge.
//  - run=1, mem_ready=1, ir=32'h4000_0000 (ROR R0,R0,R0) -> T0..T5 in 7 cycles,
//    alu_op=5'b01000 in T4, done at cycle 7.
//  - mem_ready low 3 cycles in TW -> read/mdri held 4 cycles, done at cycle 10.
//  - mem_ready never high, MEM_TIMEOUT=15 -> mem_err pulse after 15 TW cycles,
//    IDLE, no iri.
//  - ir opcode 5'b11111 -> illegal pulse in T3, no ryi/rin, back to IDLE.
//  - run dropped in T2 -> done still pulses in T5, then IDLE; assert no two
//    *o strobes ever high together.

Source files
------------

// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the hardwired control sequencer: opcode values,
// FSM state encoding, the strobe bundle and the state-to-strobe mapping.
package control_sequencer_pkg;

  localparam int OPW_DEFAULT = 5;
  localparam int TIMER_MIN_W = 4;

  // Supported R-format ALU opcodes (ir[31:27])
  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam logic [4:0] OP_SUB = 5'b00100;
  localparam logic [4:0] OP_AND = 5'b00101;
  localparam logic [4:0] OP_OR  = 5'b00110;
  localparam logic [4:0] OP_SHR = 5'b00111;
  localparam logic [4:0] OP_ROR = 5'b01000;
  localparam logic [4:0] OP_SHL = 5'b01001;
  localparam logic [4:0] OP_ROL = 5'b01010;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T0   = 3'd1,
    ST_T1   = 3'd2,
    ST_TW   = 3'd3,
    ST_T2   = 3'd4,
    ST_T3   = 3'd5,
    ST_T4   = 3'd6,
    ST_T5   = 3'd7
  } state_t;

  // One bit per datapath strobe / status pulse; the whole bundle is registered.
  typedef struct packed {
    logic pco;
    logic pci;
    logic inc_pc;
    logic mari;
    logic read;
    logic mdri;
    logic mdro;
    logic iri;
    logic ryi;
    logic zi;
    logic zlo;
    logic gra;
    logic grb;
    logic grc;
    logic rin;
    logic rout;
    logic done;
    logic illegal;
    logic mem_err;
  } strobe_t;

  // Timer must hold MEM_TIMEOUT and is never narrower than 4 bits.
  function automatic int timer_width(input int max_count);
    int w;
    w = $clog2(max_count + 1);
    return (w < TIMER_MIN_W) ? TIMER_MIN_W : w;
  endfunction

  // Strobes to present while the FSM sits in state st. bad_op only matters
  // when entering T3 (decode result); timeout only when falling back to IDLE
  // from TW. At most one bus driver (pco/mdro/zlo/rout) is set per state.
  function automatic strobe_t state_strobes(input state_t st,
                                            input logic   bad_op,
                                            input logic   timeout);
    strobe_t s;
    s = '0;
    case (st)
      ST_IDLE: s.mem_err = timeout;
      ST_T0: begin
        s.pco    = 1'b1;
        s.mari   = 1'b1;
        s.inc_pc = 1'b1;
        s.zi     = 1'b1;
      end
      ST_T1: begin
        s.zlo = 1'b1;
        s.pci = 1'b1;
      end
      ST_TW: begin
        s.read = 1'b1;
        s.mdri = 1'b1;
      end
      ST_T2: begin
        s.mdro = 1'b1;
        s.iri  = 1'b1;
      end
      ST_T3: begin
        if (bad_op) begin
          s.illegal = 1'b1;
        end else begin
          s.grb  = 1'b1;
          s.rout = 1'b1;
          s.ryi  = 1'b1;
        end
      end
      ST_T4: begin
        s.grc  = 1'b1;
        s.rout = 1'b1;
        s.zi   = 1'b1;
      end
      ST_T5: begin
        s.zlo  = 1'b1;
        s.gra  = 1'b1;
        s.rin  = 1'b1;
        s.done = 1'b1;
      end
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/control_sequencer_op_decode.sv
// Opcode legality check for the control sequencer: flags whether the
// instruction's opcode field is one of the supported ALU operations.
module control_sequencer_op_decode
  import control_sequencer_pkg::*;
#(
  parameter int OPW = OPW_DEFAULT
) (
  input  logic [OPW-1:0] i_opcode,
  output logic           o_legal
);

  // Match the opcode against the supported operation list
  always_comb begin
    o_legal = 1'b0;
    case (i_opcode)
      OPW'(OP_ADD), OPW'(OP_SUB), OPW'(OP_AND), OPW'(OP_OR),
      OPW'(OP_SHR), OPW'(OP_SHL), OPW'(OP_ROR), OPW'(OP_ROL): o_legal = 1'b1;
      default: o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: steps an R-format ALU instruction through fetch
// (T0, T1, TW, T2) and execute (T3, T4, T5), producing registered one-hot
// register-transfer strobes for the datapath. All outputs are Moore outputs
// of the state being entered, so each strobe is high for exactly the cycles
// spent in its state.
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int OPW         = OPW_DEFAULT,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic           i_clock,
  input  logic           i_clear,
  input  logic           i_run,
  input  logic           i_mem_ready,
  input  logic [31:0]    i_ir,
  output logic           o_pco,
  output logic           o_pci,
  output logic           o_inc_pc,
  output logic           o_mari,
  output logic           o_read,
  output logic           o_mdri,
  output logic           o_mdro,
  output logic           o_iri,
  output logic           o_ryi,
  output logic           o_zi,
  output logic           o_zlo,
  output logic           o_gra,
  output logic           o_grb,
  output logic           o_grc,
  output logic           o_rin,
  output logic           o_rout,
  output logic [OPW-1:0] o_alu_op,
  output logic           o_done,
  output logic           o_illegal,
  output logic           o_mem_err
);

  localparam int TMR_W = timer_width(MEM_TIMEOUT);

  state_t           r_state;
  logic [TMR_W-1:0] r_timer;
  strobe_t          r_strb;
  logic [OPW-1:0]   r_alu_op;

  state_t           w_next;
  logic             w_timeout;
  logic [TMR_W-1:0] w_tmr_inc;
  logic [OPW-1:0]   w_opcode;
  logic             w_legal;
  logic             w_unused_ir;

  assign w_opcode    = i_ir[31 -: OPW];
  assign w_unused_ir = ^i_ir[31-OPW:0];
  assign w_tmr_inc   = r_timer + TMR_W'(1);

  control_sequencer_op_decode #(
    .OPW (OPW)
  ) u_op_decode (
    .i_opcode (w_opcode),
    .o_legal  (w_legal)
  );

  // Next-state selection; TW waits for mem_ready and gives up after
  // MEM_TIMEOUT stalled cycles, T3 aborts on the decode result latched at
  // T3 entry, T5 either chains the next fetch or parks in IDLE.
  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    case (r_state)
      ST_IDLE: if (i_run) w_next = ST_T0;
      ST_T0:   w_next = ST_T1;
      ST_T1:   w_next = ST_TW;
      ST_TW: begin
        if (i_mem_ready) begin
          w_next = ST_T2;
        end else if (w_tmr_inc == TMR_W'(MEM_TIMEOUT)) begin
          w_next    = ST_IDLE;
          w_timeout = 1'b1;
        end
      end
      ST_T2:   w_next = ST_T3;
      ST_T3:   w_next = r_strb.illegal ? ST_IDLE : ST_T4;
      ST_T4:   w_next = ST_T5;
      ST_T5:   w_next = i_run ? ST_T0 : ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // State, wait timer and registered strobes for the state being entered.
  // The opcode is decoded as the FSM enters T3 and captured for the ALU as
  // it enters T4; the datapath holds ir stable across that window.
  always_ff @(posedge i_clock) begin
    if (i_clear) begin
      r_state  <= ST_IDLE;
      r_timer  <= '0;
      r_strb   <= '0;
      r_alu_op <= '0;
    end else begin
      r_state  <= w_next;
      r_timer  <= (r_state == ST_TW && w_next == ST_TW) ? w_tmr_inc : '0;
      r_strb   <= state_strobes(w_next, ~w_legal, w_timeout);
      r_alu_op <= (w_next == ST_T4) ? w_opcode : '0;
    end
  end

  assign o_pco     = r_strb.pco;
  assign o_pci     = r_strb.pci;
  assign o_inc_pc  = r_strb.inc_pc;
  assign o_mari    = r_strb.mari;
  assign o_read    = r_strb.read;
  assign o_mdri    = r_strb.mdri;
  assign o_mdro    = r_strb.mdro;
  assign o_iri     = r_strb.iri;
  assign o_ryi     = r_strb.ryi;
  assign o_zi      = r_strb.zi;
  assign o_zlo     = r_strb.zlo;
  assign o_gra     = r_strb.gra;
  assign o_grb     = r_strb.grb;
  assign o_grc     = r_strb.grc;
  assign o_rin     = r_strb.rin;
  assign o_rout    = r_strb.rout;
  assign o_alu_op  = r_alu_op;
  assign o_done    = r_strb.done;
  assign o_illegal = r_strb.illegal;
  assign o_mem_err = r_strb.mem_err;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: builds, per instruction, the expected
// cycle-by-cycle phase list from the instruction-level rules (fetch, wait,
// execute, abort paths), drives it, and compares every output each cycle.
module tb_control_sequencer;

  localparam int TMO = 15;

  localparam int P_IDLE = 0;
  localparam int P_T0   = 1;
  localparam int P_T1   = 2;
  localparam int P_TW   = 3;
  localparam int P_T2   = 4;
  localparam int P_T3   = 5;
  localparam int P_T3X  = 6;
  localparam int P_T4   = 7;
  localparam int P_T5   = 8;
  localparam int P_ERR  = 9;

  typedef struct {
    int          ph;
    bit          rdy;
    bit          run;
    logic [31:0] ir;
  } cyc_t;

  logic clk = 1'b0;
  logic clear, run, mem_ready;
  logic [31:0] ir;
  logic o_pco, o_pci, o_inc_pc, o_mari, o_read, o_mdri, o_mdro, o_iri, o_ryi;
  logic o_zi, o_zlo, o_gra, o_grb, o_grc, o_rin, o_rout, o_done, o_illegal, o_mem_err;
  logic [4:0] o_alu_op;

  logic [23:0] w_act;
  assign w_act = {o_pco, o_pci, o_inc_pc, o_mari, o_read, o_mdri, o_mdro, o_iri,
                  o_ryi, o_zi, o_zlo, o_gra, o_grb, o_grc, o_rin, o_rout,
                  o_done, o_illegal, o_mem_err, o_alu_op};

  int n_tests = 0;
  int n_fail  = 0;
  cyc_t plan[$];
  logic [23:0] obs[$];
  logic [4:0] legal_ops [8] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110,
                                5'b00111, 5'b01001, 5'b01000, 5'b01010};

  control_sequencer #(.OPW(5), .MEM_TIMEOUT(TMO)) dut (
    .i_clock(clk), .i_clear(clear), .i_run(run), .i_mem_ready(mem_ready), .i_ir(ir),
    .o_pco(o_pco), .o_pci(o_pci), .o_inc_pc(o_inc_pc), .o_mari(o_mari),
    .o_read(o_read), .o_mdri(o_mdri), .o_mdro(o_mdro), .o_iri(o_iri),
    .o_ryi(o_ryi), .o_zi(o_zi), .o_zlo(o_zlo), .o_gra(o_gra), .o_grb(o_grb),
    .o_grc(o_grc), .o_rin(o_rin), .o_rout(o_rout), .o_alu_op(o_alu_op),
    .o_done(o_done), .o_illegal(o_illegal), .o_mem_err(o_mem_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit is_legal(input logic [4:0] op);
    for (int i = 0; i < 8; i++) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  // Expected outputs for one cycle spent in a given instruction phase
  function automatic logic [23:0] exp_vec(input cyc_t c);
    logic pco, pci, inc, mari, rd, mdri, mdro, iri, ryi, zi, zlo;
    logic gra, grb, grc, rin, rout, dn, ill, err;
    logic [31:0] irv;
    logic [4:0] op;
    {pco, pci, inc, mari, rd, mdri, mdro, iri, ryi, zi, zlo} = 11'b0;
    {gra, grb, grc, rin, rout, dn, ill, err} = 8'b0;
    irv = c.ir;
    op  = 5'b0;
    case (c.ph)
      P_T0:  begin pco = 1; mari = 1; inc = 1; zi = 1; end
      P_T1:  begin zlo = 1; pci = 1; end
      P_TW:  begin rd = 1; mdri = 1; end
      P_T2:  begin mdro = 1; iri = 1; end
      P_T3:  begin grb = 1; rout = 1; ryi = 1; end
      P_T3X: ill = 1;
      P_T4:  begin grc = 1; rout = 1; zi = 1; op = irv[31:27]; end
      P_T5:  begin zlo = 1; gra = 1; rin = 1; dn = 1; end
      P_ERR: err = 1;
      default: ;
    endcase
    return {pco, pci, inc, mari, rd, mdri, mdro, iri, ryi, zi, zlo,
            gra, grb, grc, rin, rout, dn, ill, err, op};
  endfunction

  function automatic int bus_cnt(input logic [23:0] v);
    return int'(v[23]) + int'(v[17]) + int'(v[13]) + int'(v[8]);
  endfunction

  function automatic void push(input int ph, input bit rdy, input bit rn, input logic [31:0] irv);
    cyc_t c;
    c.ph = ph; c.rdy = rdy; c.run = rn; c.ir = irv;
    plan.push_back(c);
  endfunction

  function automatic void plan_idle(input int n, input bit rn);
    for (int i = 0; i < n; i++) push(P_IDLE, 1'b0, rn, $urandom);
  endfunction

  // Expected phase sequence of one instruction starting at T0; run is held
  // high through fetch and carries 'cont' from T2 onwards.
  function automatic void plan_instr(input int stall, input logic [4:0] op,
                                     input bit cont, input bit tmo);
    logic [31:0] irv;
    irv = {op, 27'($urandom)};
    push(P_T0, 0, 1, irv);
    push(P_T1, 0, 1, irv);
    if (tmo) begin
      for (int i = 0; i < TMO; i++) push(P_TW, 0, 1, irv);
      push(P_ERR, 0, cont, irv);
      return;
    end
    for (int i = 0; i <= stall; i++) push(P_TW, (i == stall), 1, irv);
    push(P_T2, 0, cont, irv);
    if (!is_legal(op)) begin
      push(P_T3X, 0, cont, irv);
      push(P_IDLE, 0, cont, irv);
      return;
    end
    push(P_T3, 0, cont, irv);
    push(P_T4, 0, cont, irv);
    push(P_T5, 0, cont, irv);
    if (!cont) push(P_IDLE, 0, 0, irv);
  endfunction

  // Play the plan: record outputs at each negedge, then drive that cycle's inputs
  task automatic drive_plan();
    obs.delete();
    foreach (plan[i]) begin
      @(negedge clk);
      obs.push_back(w_act);
      run = plan[i].run; mem_ready = plan[i].rdy; ir = plan[i].ir;
    end
  endtask

  task automatic test_reset();
    cyc_t c;
    clear = 1; run = 1; mem_ready = 1; ir = 32'h1800_0000;
    repeat (2) @(negedge clk);
    n_tests++;
    if (w_act !== 24'h0) begin n_fail++; $display("FAIL reset_outputs: got %h expected %h", w_act, 24'h0); end
    clear = 0; run = 0;
    @(negedge clk);
    n_tests++;
    if (w_act !== 24'h0) begin n_fail++; $display("FAIL reset_idle: got %h expected %h", w_act, 24'h0); end
    run = 1;
    @(negedge clk);
    run = 0;
    repeat (5) @(negedge clk);
    c.ph = P_T4; c.rdy = 0; c.run = 0; c.ir = 32'h1800_0000;
    n_tests++;
    if (w_act !== exp_vec(c)) begin n_fail++; $display("FAIL reach_t4: got %h expected %h", w_act, exp_vec(c)); end
    clear = 1;
    @(negedge clk);
    n_tests++;
    if (w_act !== 24'h0) begin n_fail++; $display("FAIL clear_in_t4: got %h expected %h", w_act, 24'h0); end
    clear = 0;
    @(negedge clk);
    n_tests++;
    if (w_act !== 24'h0) begin n_fail++; $display("FAIL idle_after_t4_clear: got %h expected %h", w_act, 24'h0); end
    mem_ready = 0;
  endtask

  task automatic test_ror();
    plan.delete();
    plan_idle(1, 1);
    plan_instr(0, 5'b01000, 1'b0, 1'b0);
    plan[1].ir = 32'h4000_0000;
    for (int i = 2; i < plan.size(); i++) plan[i].ir = 32'h4000_0000;
    drive_plan();
    foreach (plan[i]) begin
      n_tests++;
      if (obs[i] !== exp_vec(plan[i])) begin n_fail++; $display("FAIL ror cycle %0d: got %h expected %h", i, obs[i], exp_vec(plan[i])); end
    end
    n_tests++;
    if (obs[6][4:0] !== 5'b01000) begin n_fail++; $display("FAIL ror_alu_op: got %b expected %b", obs[6][4:0], 5'b01000); end
    n_tests++;
    if (obs[7][7] !== 1'b1) begin n_fail++; $display("FAIL ror_done_cycle7: got %b expected 1", obs[7][7]); end
  endtask

  task automatic test_latency();
    int cnt;
    ir = 32'h1800_0000; mem_ready = 1; run = 1;
    @(negedge clk);
    cnt = 1; run = 0;
    while (o_done !== 1'b1 && cnt < 40) begin @(negedge clk); cnt++; end
    n_tests++;
    if (cnt != 7) begin n_fail++; $display("FAIL latency: got %0d cycles expected %0d", cnt, 7); end
    @(negedge clk);
    n_tests++;
    if (w_act !== 24'h0) begin n_fail++; $display("FAIL latency_idle: got %h expected %h", w_act, 24'h0); end
    mem_ready = 0;
  endtask

  task automatic test_stall();
    int rd;
    plan.delete();
    plan_idle(1, 1);
    plan_instr(3, 5'b00100, 1'b0, 1'b0);
    drive_plan();
    rd = 0;
    foreach (plan[i]) begin
      rd += int'(obs[i][19] & obs[i][18]);
      n_tests++;
      if (obs[i] !== exp_vec(plan[i])) begin n_fail++; $display("FAIL stall cycle %0d: got %h expected %h", i, obs[i], exp_vec(plan[i])); end
    end
    n_tests++;
    if (rd != 4) begin n_fail++; $display("FAIL stall_read_cycles: got %0d expected %0d", rd, 4); end
    n_tests++;
    if (obs[10][7] !== 1'b1) begin n_fail++; $display("FAIL stall_done_cycle10: got %b expected 1", obs[10][7]); end
  endtask

  task automatic test_timeout();
    int iri;
    plan.delete();
    plan_idle(1, 1);
    plan_instr(0, 5'b00101, 1'b0, 1'b1);
    plan_idle(2, 0);
    drive_plan();
    iri = 0;
    foreach (plan[i]) begin
      iri += int'(obs[i][16]);
      n_tests++;
      if (obs[i] !== exp_vec(plan[i])) begin n_fail++; $display("FAIL timeout cycle %0d: got %h expected %h", i, obs[i], exp_vec(plan[i])); end
    end
    n_tests++;
    if (obs[3 + TMO][5] !== 1'b1) begin n_fail++; $display("FAIL timeout_mem_err: got %b expected 1", obs[3 + TMO][5]); end
    n_tests++;
    if (iri != 0) begin n_fail++; $display("FAIL timeout_no_iri: got %0d expected 0", iri); end
  endtask

  task automatic test_illegal();
    plan.delete();
    plan_idle(1, 1);
    plan_instr(0, 5'b11111, 1'b0, 1'b0);
    plan_idle(2, 0);
    drive_plan();
    foreach (plan[i]) begin
      n_tests++;
      if (obs[i] !== exp_vec(plan[i])) begin n_fail++; $display("FAIL illegal cycle %0d: got %h expected %h", i, obs[i], exp_vec(plan[i])); end
    end
    n_tests++;
    if (obs[5][6] !== 1'b1 || obs[5][15] !== 1'b0) begin n_fail++; $display("FAIL illegal_t3: got %h expected illegal=1 ryi=0", obs[5]); end
  endtask

  task automatic test_run_drop();
    plan.delete();
    plan_idle(1, 1);
    plan_instr(1, 5'b01010, 1'b0, 1'b0);
    plan_idle(3, 0);
    drive_plan();
    foreach (plan[i]) begin
      n_tests++;
      if (obs[i] !== exp_vec(plan[i])) begin n_fail++; $display("FAIL run_drop cycle %0d: got %h expected %h", i, obs[i], exp_vec(plan[i])); end
      n_tests++;
      if (bus_cnt(obs[i]) > 1) begin n_fail++; $display("FAIL run_drop_bus cycle %0d: got %0d drivers expected <=1", i, bus_cnt(obs[i])); end
    end
  endtask

  task automatic test_back_to_back();
    int stall;
    bit tmo, cont, last;
    logic [4:0] op;
    plan.delete();
    plan_idle(1, 1);
    for (int k = 0; k < 24; k++) begin
      last  = (k == 23);
      stall = $urandom_range(0, 4);
      tmo   = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 1) == 1) op = legal_ops[$urandom_range(0, 7)];
      else op = 5'($urandom);
      cont  = last ? 1'b0 : ($urandom_range(0, 3) != 0);
      plan_instr(stall, op, cont, tmo);
      if (!cont && !last) plan_idle(1, 1);
    end
    plan_idle(2, 0);
    drive_plan();
    foreach (plan[i]) begin
      n_tests++;
      if (obs[i] !== exp_vec(plan[i])) begin n_fail++; $display("FAIL b2b cycle %0d phase %0d: got %h expected %h", i, plan[i].ph, obs[i], exp_vec(plan[i])); end
      n_tests++;
      if (bus_cnt(obs[i]) > 1) begin n_fail++; $display("FAIL b2b_bus cycle %0d: got %0d drivers expected <=1", i, bus_cnt(obs[i])); end
    end
  endtask

  initial begin
    clear = 1; run = 0; mem_ready = 0; ir = 32'h0;
    test_reset();
    test_ror();
    test_latency();
    test_stall();
    test_timeout();
    test_illegal();
    test_run_drop();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
